ped_crossing_unit: RTL and testbench

Pedestrian-side counterpart of the traffic light controller. It debounces the raw crossing push-button and drives the controller's `pedestrian_button` request input. It watches the controller's one-hot `lights` bus to decide when crossing is safe, then sequences the WALK / flashing DON'T WALK pedestrian lamps with a countdown display. It sits beside the light controller on the same `clk`/`reset` domain and flags unsafe light states.

---
 rtl/ped_xing_pkg.sv | 24 ++
 rtl/button_debouncer.sv | 52 +++++
 rtl/ped_crossing_unit.sv | 129 ++++++++++++
 tb/tb_ped_crossing_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ped_xing_pkg.sv
// Purpose: shared light encodings and crossing FSM states for the pedestrian unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ped_xing_pkg;

    // Lamp encodings on the light controller's one-hot lights bus.
    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WALK,
        CLEAR,
        FAULT
    } xing_state_t;

    // Exactly one of the three legal lamp codes; zero or multi-hot is illegal.
    function automatic logic lights_legal(input logic [2:0] l);
        return (l == RED) || (l == YELLOW) || (l == GREEN);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Purpose: synchronise and debounce the raw push-button, emit a one-cycle press pulse.
// Latency: db follows a held level change 1+DEBOUNCE_CYCLES edges after first sample.
// Backpressure: none; free-running, press is a single-cycle pulse.
//
// Ports: clk, reset (async, active-high), button_raw (async, bouncy),
//        db (debounced level), press (db rising edge, one cycle).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic db,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          db_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            db      <= 1'b0;
            db_prev <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= button_raw;
            s2      <= s1;
            db_prev <= db;
            if (s2 != db) begin
                // The DEBOUNCE_CYCLES-th consecutive differing edge commits the level.
                if (cnt == CNT_LAST) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = db & ~db_prev;

endmodule

// File: rtl/ped_crossing_unit.sv
// Purpose: pedestrian crossing sequencer beside the traffic light controller.
// Latency: request 2+DEBOUNCE_CYCLES edges after press; WALK on 2nd consecutive RED.
// Backpressure: none; presses during WALK/CLEAR are queued once, presses in FAULT dropped.
//
// Ports: clk, reset (async, active-high), button_raw (async), lights[2:0] (one-hot),
//        pedestrian_button, walk, dont_walk, countdown[CNT_W-1:0], fault (sticky).
module ped_crossing_unit
    import ped_xing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 8,   // must be <= 2**CNT_W
    parameter int FLASH_CYCLES    = 6,   // must be <= 2**CNT_W
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_raw,
    input  logic [2:0]       lights,
    output logic             pedestrian_button,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);

    xing_state_t      state;
    logic [CNT_W-1:0] timer;
    logic [1:0]       red_cnt;
    logic [1:0]       red_cnt_inc;
    logic             pending;
    logic             flash_on;
    logic             btn_db;
    logic             btn_press;
    logic             press_evt;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .reset      (reset),
        .button_raw (button_raw),
        .db         (btn_db),
        .press      (btn_press)
    );

    // A press is only honoured while the debounced level is actually high.
    assign press_evt = btn_press & btn_db;

    // Consecutive-RED counter, saturating at 2.
    assign red_cnt_inc = (red_cnt == 2'd2) ? 2'd2 : red_cnt + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            red_cnt  <= '0;
            pending  <= 1'b0;
            flash_on <= 1'b0;
        end else if (state != FAULT && !lights_legal(lights)) begin
            // Illegal lamp code wins over everything; a coincident press is dropped.
            state <= FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (press_evt || pending) begin
                        state   <= REQUEST;
                        pending <= 1'b0;
                        red_cnt <= '0;
                    end
                end
                REQUEST: begin
                    if (lights == RED) begin
                        red_cnt <= red_cnt_inc;
                        if (red_cnt_inc == 2'd2) begin
                            state <= WALK;
                            timer <= WALK_LOAD;
                        end
                    end else begin
                        red_cnt <= '0;
                    end
                end
                WALK: begin
                    if (lights == GREEN) begin
                        state <= FAULT;
                    end else begin
                        if (press_evt) begin
                            pending <= 1'b1;
                        end
                        if (timer == '0) begin
                            state    <= CLEAR;
                            timer    <= FLASH_LOAD;
                            flash_on <= 1'b1;
                        end else begin
                            timer <= timer - CNT_W'(1);
                        end
                    end
                end
                CLEAR: begin
                    flash_on <= ~flash_on;
                    if (press_evt) begin
                        pending <= 1'b1;
                    end
                    if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

    // Outputs decode purely from registered state, timer and flash bit.
    assign pedestrian_button = (state == REQUEST);
    assign walk              = (state == WALK);
    assign dont_walk         = (state == CLEAR) ? flash_on : (state != WALK);
    assign countdown         = (state == WALK || state == CLEAR) ? timer : '0;
    assign fault             = (state == FAULT);

endmodule

// File: tb/tb_ped_crossing_unit.sv
// Purpose: directed self-checking bench for ped_crossing_unit with default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_ped_crossing_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       button_raw;
    logic [2:0] lights;
    logic       pedestrian_button;
    logic       walk;
    logic       dont_walk;
    logic [3:0] countdown;
    logic       fault;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    ped_crossing_unit #(
        .DEBOUNCE_CYCLES (4),
        .WALK_CYCLES     (8),
        .FLASH_CYCLES    (6),
        .CNT_W           (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .button_raw        (button_raw),
        .lights            (lights),
        .pedestrian_button (pedestrian_button),
        .walk              (walk),
        .dont_walk         (dont_walk),
        .countdown         (countdown),
        .fault             (fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed as {pedestrian_button, walk, dont_walk, countdown[3:0], fault}.
    task automatic chk_outs(input string tag, input logic pb, input logic w, input logic dw,
                            input logic [3:0] cd, input logic f);
        chk(tag, {24'd0, pedestrian_button, walk, dont_walk, countdown, fault},
                 {24'd0, pb, w, dw, cd, f});
    endtask

    initial begin
        reset      = 1'b1;
        button_raw = 1'b0;
        lights     = 3'b010;
        tick();
        chk_outs("reset_state", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk_outs("idle", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);

        // 3-cycle glitch must not produce a request.
        button_raw = 1'b1;
        repeat (3) tick();
        button_raw = 1'b0;
        repeat (10) begin
            tick();
            chk("glitch_no_req", {31'd0, pedestrian_button}, 32'd0);
        end

        // Held press: request appears after edge 6.
        button_raw = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("press_lat_e%0d", k), {31'd0, pedestrian_button}, 32'd0);
        end
        tick();
        chk_outs("request_e6", 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        button_raw = 1'b0;

        // Full crossing.
        lights = 3'b001;
        tick();
        chk_outs("red1_still_req", 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        chk_outs("walk_cd7", 1'b0, 1'b1, 1'b0, 4'd7, 1'b0);
        for (int c = 6; c >= 0; c--) begin
            tick();
            chk_outs($sformatf("walk_cd%0d", c), 1'b0, 1'b1, 1'b0, 4'(c), 1'b0);
        end
        for (int c = 5; c >= 0; c--) begin
            tick();
            chk_outs($sformatf("clear_cd%0d", c), 1'b0, 1'b0, c[0], 4'(c), 1'b0);
        end
        tick();
        chk_outs("idle_after_clear", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        chk_outs("idle_no_pending", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);

        // RED not stable: RED, YELLOW, RED, RED.
        lights     = 3'b010;
        button_raw = 1'b1;
        repeat (7) tick();
        chk_outs("req2", 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        button_raw = 1'b0;
        lights = 3'b001;
        tick();
        chk_outs("unstable_r", 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        lights = 3'b010;
        tick();
        chk_outs("unstable_ry", 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        lights = 3'b001;
        tick();
        chk_outs("unstable_ryr", 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        chk_outs("unstable_walk", 1'b0, 1'b1, 1'b0, 4'd7, 1'b0);

        // Queued press during WALK/CLEAR.
        repeat (3) tick();
        button_raw = 1'b1;
        repeat (4) tick();
        chk_outs("q_walk_end", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (6) tick();
        chk_outs("q_clear_end", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        chk_outs("q_idle_gap", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        chk_outs("q_rerequest", 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);

        // Reset mid-WALK acts immediately.
        tick();
        tick();
        chk_outs("walk_again", 1'b0, 1'b1, 1'b0, 4'd7, 1'b0);
        tick();
        reset      = 1'b1;
        button_raw = 1'b0;
        #1;
        chk_outs("reset_midwalk", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Illegal encoding in IDLE, then presses ignored.
        lights = 3'b011;
        tick();
        chk_outs("fault_illegal", 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
        lights     = 3'b001;
        button_raw = 1'b1;
        repeat (10) tick();
        chk_outs("fault_sticky1", 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
        button_raw = 1'b0;
        repeat (8) tick();
        button_raw = 1'b1;
        repeat (10) tick();
        chk_outs("fault_sticky2", 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);

        // Button held through reset release: one press after normal latency.
        reset  = 1'b1;
        lights = 3'b010;
        #1;
        chk_outs("reset_from_fault", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        reset = 1'b0;
        n = 0;
        while (!pedestrian_button && n < 20) begin
            tick();
            n++;
        end
        chk("held_reset_press_edges", n, 32'd7);

        // GREEN during WALK.
        lights = 3'b001;
        tick();
        tick();
        chk_outs("walk_pre_green", 1'b0, 1'b1, 1'b0, 4'd7, 1'b0);
        lights = 3'b100;
        tick();
        chk_outs("fault_green", 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
        lights = 3'b001;
        repeat (3) tick();
        chk_outs("fault_green_sticky", 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
